// File: rtl/encode_dpx_if.sv
// encode_dpx_if -- stream bus for the encode_dpx byte unpacker.
//   Input side : in_data / in_valid / in_last / in_nbytes  ->  in_ready
//   Output side: out_byte / out_valid / out_last / out_idx / cand_*  <-  out_ready
// Modports:
//   master : the producer of words and consumer of bytes (testbench / upstream)
//   slave  : the unpacker itself
interface encode_dpx_if #(
    parameter int IN_BYTES  = 8,
    parameter int LZF_WIDTH = 20
);
    localparam int NBW = $clog2(IN_BYTES) + 1;

    logic [8*IN_BYTES-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic [NBW-1:0]        in_nbytes;
    logic                  in_ready;

    logic [7:0]            out_byte;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [LZF_WIDTH-1:0]  out_idx;
    logic [LZF_WIDTH-1:0]  cand_ref;
    logic [7:0]            cand_b0;
    logic [7:0]            cand_b1;

    modport master (
        output in_data, in_valid, in_last, in_nbytes, out_ready,
        input  in_ready, out_byte, out_valid, out_last, out_idx,
               cand_ref, cand_b0, cand_b1
    );

    modport slave (
        input  in_data, in_valid, in_last, in_nbytes, out_ready,
        output in_ready, out_byte, out_valid, out_last, out_idx,
               cand_ref, cand_b0, cand_b1
    );
endinterface

// File: rtl/encode_dpx.sv
// encode_dpx -- unpacks IN_BYTES-wide words into a byte stream and, for every
// emitted byte, looks up a 2-byte hash table (LZF-style match candidate) and
// records the byte in a history buffer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   word input stream / byte output stream with candidate info
//   hraddr        history read address
//   hdata         history data, one cycle after hraddr
//   done          block fully emitted; held until rst
module encode_dpx #(
    parameter int IN_BYTES  = 8,
    parameter int LZF_WIDTH = 20,
    parameter int HASH_AW   = 8,
    parameter int HIST_AW   = 11
) (
    input  logic               clk,
    input  logic               rst,
    encode_dpx_if.slave        bus,
    input  logic [HIST_AW-1:0] hraddr,
    output logic [7:0]         hdata,
    output logic               done
);
    localparam int LW = $clog2(IN_BYTES);
    localparam int HW = 16 + LZF_WIDTH;
    localparam logic [LW:0] ONE  = (LW+1)'(1);
    localparam logic [LW:0] FULL = (LW+1)'(IN_BYTES);

    typedef enum logic [1:0] {INIT, IDLE, UNPACK, DONE} state_t;

    state_t                        state_q, state_d;
    logic [HASH_AW-1:0]            init_cnt_q;
    logic [IN_BYTES-1:0][7:0]      word_q;
    logic [LW:0]                   limit_q;
    logic                          lastf_q;
    logic [LW-1:0]                 lane_q;
    logic [LZF_WIDTH-1:0]          idx_q;
    logic [7:0]                    prev_q;

    logic                          out_valid_q, out_last_q;
    logic [7:0]                    out_byte_q, cand_b0_q, cand_b1_q, hdata_q;
    logic [LZF_WIDTH-1:0]          out_idx_q, cand_ref_q;

    // Entry layout: {cur byte, prev byte, stream index}
    logic [HW-1:0]                 htab [2**HASH_AW];
    logic [7:0]                    hist [2**HIST_AW];

    logic [7:0]                    cur;
    logic                          lane_last;
    logic                          load;
    logic [10:0]                   hfull;
    logic [HASH_AW-1:0]            h;
    logic [HW-1:0]                 hent;
    logic                          in_ready_c, done_c;

    // Datapath combinational
    always_comb begin
        cur       = word_q[lane_q];
        lane_last = ({1'b0, lane_q} == (limit_q - ONE));
        // Out stage accepts a new byte when empty or draining this cycle.
        load      = (state_q == UNPACK) && (!out_valid_q || bus.out_ready);
        hfull     = {prev_q, 3'b000} ^ {3'b000, cur};
        h         = HASH_AW'(hfull);
        hent      = htab[h];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:   if (init_cnt_q == '1) state_d = IDLE;
            IDLE:   if (bus.in_valid) state_d = UNPACK;
            UNPACK: if (load && lane_last) state_d = lastf_q ? DONE : IDLE;
            DONE:   state_d = DONE;
            default: state_d = INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_c = (state_q == IDLE) && !rst;
        // Done only once the final byte has left the out stage.
        done_c     = (state_q == DONE) && !out_valid_q && !rst;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q  <= '0;
            word_q      <= '0;
            limit_q     <= '0;
            lastf_q     <= 1'b0;
            lane_q      <= '0;
            idx_q       <= '0;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_byte_q  <= '0;
            out_idx_q   <= '0;
            cand_ref_q  <= '0;
            cand_b0_q   <= '0;
            cand_b1_q   <= '0;
            hdata_q     <= '0;
        end else begin
            if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;

            if (state_q == IDLE && bus.in_valid) begin
                word_q  <= bus.in_data;
                limit_q <= bus.in_last ? bus.in_nbytes : FULL;
                lastf_q <= bus.in_last;
                lane_q  <= '0;
            end

            if (load) begin
                out_valid_q <= 1'b1;
                out_byte_q  <= cur;
                out_last_q  <= lastf_q && lane_last;
                out_idx_q   <= idx_q;
                cand_b0_q   <= hent[HW-1 -: 8];
                cand_b1_q   <= hent[HW-9 -: 8];
                cand_ref_q  <= hent[LZF_WIDTH-1:0];
                lane_q      <= lane_q + 1'b1;
                idx_q       <= idx_q + LZF_WIDTH'(1);
                prev_q      <= cur;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            hdata_q <= hist[hraddr];
        end
    end

    // Memories: no reset; the hash table is cleared by the INIT sweep.
    // Lookup above reads the pre-update entry on the same edge as the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) htab[init_cnt_q] <= '0;
            else if (load)       htab[h] <= {cur, prev_q, idx_q};
            if (load) hist[idx_q[HIST_AW-1:0]] <= cur;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.cand_ref  = cand_ref_q;
    assign bus.cand_b0   = cand_b0_q;
    assign bus.cand_b1   = cand_b1_q;
    assign hdata         = hdata_q;
    assign done          = done_c;
endmodule

// File: tb/tb_encode_dpx.sv
module tb_encode_dpx;
    localparam int IN_BYTES  = 8;
    localparam int LZF_WIDTH = 20;
    localparam int HASH_AW   = 8;
    localparam int HIST_AW   = 11;

    logic               clk = 1'b0;
    logic               rst;
    logic [HIST_AW-1:0] hraddr;
    logic [7:0]         hdata;
    logic               done;

    always #5 clk = ~clk;

    encode_dpx_if #(.IN_BYTES(IN_BYTES), .LZF_WIDTH(LZF_WIDTH)) bus ();

    encode_dpx #(
        .IN_BYTES(IN_BYTES), .LZF_WIDTH(LZF_WIDTH),
        .HASH_AW(HASH_AW), .HIST_AW(HIST_AW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .hraddr(hraddr), .hdata(hdata), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]           q_byte [$];
    logic [LZF_WIDTH-1:0] q_idx  [$];
    bit                   q_last [$];
    logic [LZF_WIDTH-1:0] q_cref [$];
    logic [7:0]           q_cb0  [$];
    logic [7:0]           q_cb1  [$];
    int last_cyc, done_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for two cycles, release, count edges until in_ready.
    task automatic reset_and_init(output int n);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nb);
        int w = 0;
        while (!bus.in_ready && w < 100) begin
            step();
            w++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_word_timeout in_ready=%0b required=1", bus.in_ready);
        end
        bus.in_data   = d;
        bus.in_last   = last;
        bus.in_nbytes = nb;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
    endtask

    // Record transferred bytes with out_ready=1 until done or budget.
    task automatic collect(input int budget);
        q_byte.delete(); q_idx.delete(); q_last.delete();
        q_cref.delete(); q_cb0.delete(); q_cb1.delete();
        last_cyc = -1;
        done_cyc = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (bus.out_valid && bus.out_ready) begin
                q_byte.push_back(bus.out_byte);
                q_idx.push_back(bus.out_idx);
                q_last.push_back(bus.out_last);
                q_cref.push_back(bus.cand_ref);
                q_cb0.push_back(bus.cand_b0);
                q_cb1.push_back(bus.cand_b1);
                if (bus.out_last) last_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.in_nbytes = '0;
        hraddr = '0;
        step();
        step();
        checks++;
        if ({bus.in_ready, bus.out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags ready/valid/done=%b required=000",
                     {bus.in_ready, bus.out_valid, done});
        end
        checks++;
        if (bus.out_byte !== 8'h00 || bus.out_idx !== '0 || bus.cand_ref !== '0 ||
            bus.cand_b0 !== 8'h00 || bus.cand_b1 !== 8'h00 || hdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_data byte=%h idx=%h cref=%h b0=%h b1=%h hdata=%h required all 0",
                     bus.out_byte, bus.out_idx, bus.cand_ref, bus.cand_b0, bus.cand_b1, hdata);
        end
        rst = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL init_length edges=%0d required=256", n);
        end
    endtask

    task automatic test_single_word();
        bus.out_ready = 1'b1;
        bus.in_data   = 64'h0706050403020100;
        bus.in_last   = 1'b1;
        bus.in_nbytes = 4'd8;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early out_valid=%b required=0", bus.out_valid);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h00 || bus.out_idx !== '0) begin
            errors++;
            $display("FAIL latency_first valid=%b byte=%h idx=%0d required 1/00/0",
                     bus.out_valid, bus.out_byte, bus.out_idx);
        end
        collect(100);
        checks++;
        if (q_byte.size() != 8) begin
            errors++;
            $display("FAIL single_count got=%0d required=8", q_byte.size());
        end
        for (int i = 0; i < q_byte.size() && i < 8; i++) begin
            checks++;
            if (q_byte[i] !== 8'(i) || q_idx[i] !== LZF_WIDTH'(i) || q_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL single_byte%0d byte=%h idx=%0d last=%b required %h/%0d/%b",
                         i, q_byte[i], q_idx[i], q_last[i], 8'(i), i, (i == 7));
            end
        end
        checks++;
        if (last_cyc < 0 || done_cyc != last_cyc + 1) begin
            errors++;
            $display("FAIL done_timing done_cyc=%0d required=%0d", done_cyc, last_cyc + 1);
        end
        // Further offers are ignored and done holds.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (done !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_hold done=%b ready=%b valid=%b required 1/0/0",
                     done, bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        bit have_snap = 0;
        logic [7:0] s_byte;
        logic [LZF_WIDTH-1:0] s_idx;
        logic s_last;
        int unstable = 0;
        reset_and_init(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL b2b_init edges=%0d required=256", n);
        end
        q_byte.delete(); q_idx.delete(); q_last.delete();
        fork
            begin
                send_word(64'h1716151413121110, 1'b0, 4'd8);
                send_word(64'h1f1e1d1c1b1a1918, 1'b1, 4'd8);
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = (i % 2 == 0);
            if (have_snap) begin
                if (bus.out_byte !== s_byte || bus.out_idx !== s_idx ||
                    bus.out_last !== s_last || bus.out_valid !== 1'b1) unstable++;
            end
            have_snap = bus.out_valid && !bus.out_ready;
            s_byte = bus.out_byte;
            s_idx  = bus.out_idx;
            s_last = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                q_byte.push_back(bus.out_byte);
                q_idx.push_back(bus.out_idx);
                q_last.push_back(bus.out_last);
            end
            if (done) break;
            step();
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL b2b_stable unstable_cycles=%0d required=0", unstable);
        end
        checks++;
        if (q_byte.size() != 16) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=16", q_byte.size());
        end
        for (int i = 0; i < q_byte.size() && i < 16; i++) begin
            checks++;
            if (q_byte[i] !== 8'(8'h10 + i) || q_idx[i] !== LZF_WIDTH'(i) || q_last[i] !== (i == 15)) begin
                errors++;
                $display("FAIL b2b_byte%0d byte=%h idx=%0d last=%b required %h/%0d/%b",
                         i, q_byte[i], q_idx[i], q_last[i], 8'(8'h10 + i), i, (i == 15));
            end
        end
    endtask

    task automatic test_partial();
        int n;
        reset_and_init(n);
        bus.out_ready = 1'b1;
        send_word(64'hEEEEEEEEEE332211, 1'b1, 4'd3);
        collect(100);
        checks++;
        if (q_byte.size() != 3) begin
            errors++;
            $display("FAIL partial_count got=%0d required=3", q_byte.size());
        end
        checks++;
        if (q_byte.size() == 3 &&
            (q_byte[0] !== 8'h11 || q_byte[1] !== 8'h22 || q_byte[2] !== 8'h33 ||
             q_last[0] || q_last[1] || !q_last[2])) begin
            errors++;
            $display("FAIL partial_data bytes=%h %h %h last=%b%b%b required 11 22 33 last=001",
                     q_byte[0], q_byte[1], q_byte[2], q_last[0], q_last[1], q_last[2]);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.out_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL partial_tail valid=%b done=%b required 0/1", bus.out_valid, done);
        end
    endtask

    task automatic test_hash_history();
        int n;
        reset_and_init(n);
        bus.out_ready = 1'b1;
        send_word(64'h0000000062616261, 1'b1, 4'd4);
        collect(100);
        checks++;
        if (q_byte.size() != 4) begin
            errors++;
            $display("FAIL hash_count got=%0d required=4", q_byte.size());
        end
        if (q_byte.size() == 4) begin
            checks++;
            if (q_cref[0] !== '0 || q_cb0[0] !== 8'h00 || q_cb1[0] !== 8'h00 || q_cref[2] !== '0) begin
                errors++;
                $display("FAIL hash_fresh cref0=%0d b0=%h b1=%h cref2=%0d required 0/00/00/0",
                         q_cref[0], q_cb0[0], q_cb1[0], q_cref[2]);
            end
            checks++;
            if (q_cref[3] !== LZF_WIDTH'(1) || q_cb0[3] !== 8'h62 || q_cb1[3] !== 8'h61) begin
                errors++;
                $display("FAIL hash_match cref=%0d b0=%h b1=%h required 1/62/61",
                         q_cref[3], q_cb0[3], q_cb1[3]);
            end
        end
        hraddr = 11'd1;
        step();
        checks++;
        if (hdata !== 8'h62) begin
            errors++;
            $display("FAIL hist_addr1 hdata=%h required=62", hdata);
        end
        hraddr = 11'd2;
        step();
        checks++;
        if (hdata !== 8'h61) begin
            errors++;
            $display("FAIL hist_addr2 hdata=%h required=61", hdata);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        reset_and_init(n);
        bus.out_ready = 1'b0;
        send_word(64'h4746454443424140, 1'b1, 4'd8);
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h40) begin
            errors++;
            $display("FAIL midrst_stall valid=%b byte=%h required 1/40", bus.out_valid, bus.out_byte);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear valid=%b ready=%b required 0/0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL midrst_init edges=%0d required=256", n);
        end
        bus.out_ready = 1'b1;
        send_word(64'h5756555453525150, 1'b1, 4'd8);
        collect(100);
        checks++;
        if (q_byte.size() != 8 || q_idx[0] !== '0 || q_byte[0] !== 8'h50 ||
            q_idx[7] !== LZF_WIDTH'(7) || q_byte[7] !== 8'h57) begin
            errors++;
            $display("FAIL midrst_restart count=%0d first_idx=%0d first_byte=%h required 8/0/50",
                     q_byte.size(), (q_idx.size() > 0) ? q_idx[0] : '1,
                     (q_byte.size() > 0) ? q_byte[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_partial();
        test_hash_history();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/encode_dpx.md
ENCODE_DPX -- requirements
Module: encode_dpx

Interface
REQ-001 SHALL have parameter IN_BYTES, default 8, bytes per input word (power of 2, 2..16).
REQ-002 SHALL have parameter LZF_WIDTH, default 20, width of the byte index counter.
REQ-003 SHALL have parameter HASH_AW, default 8, hash table address width (8..12).
REQ-004 SHALL have parameter HIST_AW, default 11, history buffer address width.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports are clk and rst.
REQ-006 Port clk  in  1  clock.
REQ-007 Port rst  in  1  synchronous active-high reset.
REQ-008 Port in_data  in  8*IN_BYTES  packed input word, byte 0 at bits [7:0].
REQ-009 Port in_valid  in  1  input word valid.
REQ-010 Port in_last  in  1  word is the final word of the block.
REQ-011 Port in_nbytes  in  clog2(IN_BYTES)+1  valid byte count of the last word (1..IN_BYTES); ignored unless in_last.
REQ-012 Port in_ready  out  1  word accepted when in_valid&in_ready.
REQ-013 Port out_byte  out  8  unpacked byte.
REQ-014 Port out_valid  out  1  out stage holds a byte.
REQ-015 Port out_ready  in  1  consumer accepts when out_valid&out_ready.
REQ-016 Port out_last  out  1  out_byte is the final byte of the block.
REQ-017 Port out_idx  out  LZF_WIDTH  index of out_byte in the stream.
REQ-018 Port cand_ref  out  LZF_WIDTH  hash-table index entry for out_byte.
REQ-019 Port cand_b0, cand_b1  out  8 each  stored current/previous bytes of that entry.
REQ-020 Port hraddr  in  HIST_AW  history read address.
REQ-021 Port hdata  out  8  history data.
REQ-022 Port done  out  1  block fully emitted.

Function
REQ-023 SHALL have states INIT, IDLE, UNPACK, DONE.
REQ-024 INIT: write zero to hash entries 0..2^HASH_AW-1, one per cycle; enter IDLE after the last entry; in_ready=0.
REQ-025 IDLE: in_ready=1; on accept, latch word, byte limit = in_last ? in_nbytes : IN_BYTES, and last flag; go UNPACK with lane=0.
REQ-026 UNPACK: in_ready=0; out stage loads byte[lane] when out stage is empty or being drained that cycle; lane increments per load.
REQ-027 On loading the final lane (lane=limit-1): last flag clear -> IDLE; set -> DONE, out_last=1 with that byte.
REQ-028 out_byte, out_last, out_idx, cand_* SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Hash h = ({prev,3'b000} XOR {3'b000,cur}) zero-extended or truncated to HASH_AW bits; prev = previously loaded byte (0 after reset).
REQ-030 On each load, cand_* SHALL take htab[h] before update; the same edge writes htab[h]={cur,prev,idx} (read-old-data).
REQ-031 On each load, history[idx mod 2^HIST_AW] <= cur; hdata <= history[hraddr] every cycle (1-cycle latency; same-address collision returns old data).
REQ-032 idx increments per load, wraps modulo 2^LZF_WIDTH.
REQ-033 Latency: word accept to first out_valid = 2 cycles; sustained 1 byte/cycle with out_ready=1; no bubble between words beyond the 1 IDLE cycle.
REQ-034 DONE: done=1 after the last byte transfers; no further accepts; held until rst.

Reset
REQ-035 rst SHALL force state INIT, all outputs 0 (in_ready, out_valid, done, out_byte, out_idx, cand_*, hdata), idx=0, prev=0, lane=0.
REQ-036 rst mid-UNPACK SHALL discard the buffered word and restart INIT on the next cycle.

Verification
REQ-037 Reset, wait 2^HASH_AW cycles -> in_ready rises on cycle 257 (defaults); any lookup returns cand_ref=0.
REQ-038 One word 0x0706050403020100 with in_last, in_nbytes=8, out_ready=1 -> bytes 00..07, out_idx 0..7, out_last on 07, done next cycle.
REQ-039 Two words, out_ready toggled 1/0 each cycle -> all 16 bytes in order, outputs stable in low cycles, no loss or duplicate.
REQ-040 Last word in_nbytes=3 -> exactly 3 bytes emitted, out_last on third.
REQ-041 Stream "abab" -> on 2nd 'b' (idx 3) cand_ref=1, cand_b0='b', cand_b1='a'; hraddr=1 returns 'b'.
REQ-042 Assert rst mid-word -> out_valid=0 next cycle, INIT replays, next block starts at out_idx=0.
